// File: rtl/apb_master_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_master_arb_if : requester-side and APB-side signal bundle for the      |
// |                     two-requester APB master.  Rev 1.0                     |
// +----------------------------------------------------------------------------+
interface apb_master_arb_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 6
);
  localparam int STRB_SIZE = DATA_SIZE / 8;

  logic                 req0_valid;
  logic                 req0_write;
  logic [ADDR_SIZE-1:0] req0_addr;
  logic [DATA_SIZE-1:0] req0_wdata;
  logic [STRB_SIZE-1:0] req0_strb;
  logic                 req0_ack;
  logic                 req0_done;
  logic [DATA_SIZE-1:0] req0_rdata;
  logic                 req0_err;

  logic                 req1_valid;
  logic                 req1_write;
  logic [ADDR_SIZE-1:0] req1_addr;
  logic [DATA_SIZE-1:0] req1_wdata;
  logic [STRB_SIZE-1:0] req1_strb;
  logic                 req1_ack;
  logic                 req1_done;
  logic [DATA_SIZE-1:0] req1_rdata;
  logic                 req1_err;

  logic [ADDR_SIZE-1:0] PADDR;
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [DATA_SIZE-1:0] PWDATA;
  logic [STRB_SIZE-1:0] PSTROBE;
  logic                 PREADY;
  logic [DATA_SIZE-1:0] PRDATA;
  logic                 PSLVERR;

  // master: the arbitrating APB master; slave: requesters plus the APB slave
  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata, req0_strb,
    output req0_ack, req0_done, req0_rdata, req0_err,
    input  req1_valid, req1_write, req1_addr, req1_wdata, req1_strb,
    output req1_ack, req1_done, req1_rdata, req1_err,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTROBE,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata, req0_strb,
    input  req0_ack, req0_done, req0_rdata, req0_err,
    output req1_valid, req1_write, req1_addr, req1_wdata, req1_strb,
    input  req1_ack, req1_done, req1_rdata, req1_err,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTROBE,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

`default_nettype wire

// File: rtl/apb_master_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_master_arb : round-robin two-requester APB master, one transfer at a   |
// |                  time. Optional ACCESS timeout under macro APB_TIMEOUT_EN. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module apb_master_arb #(
  parameter int DATA_SIZE      = 32,
  parameter int ADDR_SIZE      = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic        PCLK,
  input  wire logic        PRESET,
  apb_master_arb_if.master bus
);
  localparam int STRB_SIZE = DATA_SIZE / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 owner_q, owner_d;
  logic [ADDR_SIZE-1:0] paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [DATA_SIZE-1:0] pwdata_q, pwdata_d;
  logic [STRB_SIZE-1:0] pstrb_q, pstrb_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 done0_q, done0_d, done1_q, done1_d;
  logic [DATA_SIZE-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                 err0_q, err0_d, err1_q, err1_d;

  logic                 grant_valid, grant_id;
  logic                 ack0, ack1;
  logic                 finish;
  logic [DATA_SIZE-1:0] cap_rdata;
  logic                 cap_err;
  logic                 tmo_hit;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_hit   = 1'b0;
    if (state_q == SETUP) begin
      tmo_cnt_d = '0;
    end else if (state_q == ACCESS && !bus.PREADY) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      tmo_hit   = (tmo_cnt_d == CNT_W'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout;
  assign tmo_hit        = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Tie goes to the requester that did not win last time
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant_id = ~last_grant_q;
    else                                  grant_id = bus.req1_valid;
  end

  // A timeout ends the transfer with err=1 and zero read data; PREADY on that cycle wins
  always_comb begin
    finish    = bus.PREADY | tmo_hit;
    cap_rdata = bus.PREADY ? bus.PRDATA : '0;
    cap_err   = bus.PREADY ? bus.PSLVERR : 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;
    ack0         = 1'b0;
    ack1         = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          ack0         = ~grant_id;
          ack1         = grant_id;
          owner_d      = grant_id;
          last_grant_d = grant_id;
          pwrite_d     = grant_id ? bus.req1_write : bus.req0_write;
          paddr_d      = grant_id ? bus.req1_addr  : bus.req0_addr;
          pwdata_d     = grant_id ? bus.req1_wdata : bus.req0_wdata;
          pstrb_d      = grant_id ? bus.req1_strb  : bus.req0_strb;
          psel_d       = 1'b1;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (finish) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
          if (owner_q) begin
            done1_d = 1'b1;
            err1_d  = cap_err;
            if (!pwrite_q) rdata1_d = cap_rdata;
          end else begin
            done0_d = 1'b1;
            err0_d  = cap_err;
            if (!pwrite_q) rdata0_d = cap_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  assign bus.req0_ack   = ack0;
  assign bus.req1_ack   = ack1;
  assign bus.req0_done  = done0_q;
  assign bus.req1_done  = done1_q;
  assign bus.req0_rdata = rdata0_q;
  assign bus.req1_rdata = rdata1_q;
  assign bus.req0_err   = err0_q;
  assign bus.req1_err   = err1_q;
  assign bus.PADDR      = paddr_q;
  assign bus.PSEL       = psel_q;
  assign bus.PENABLE    = penable_q;
  assign bus.PWRITE     = pwrite_q;
  assign bus.PWDATA     = pwdata_q;
  assign bus.PSTROBE    = pstrb_q;
endmodule

`default_nettype wire
